ifetch_prefetch: RTL and testbench

- Instruction fetch stage directly upstream of the 8-bit accumulator CPU's execute stage.
- Owns the program counter and issues reads to a synchronous instruction ROM (1024 x 14 bits, 1-cycle read latency).
- Buffers returned words in a small prefetch FIFO and presents them to execute over a valid/ready handshake.
- Accepts redirects (jmp/jz/jc/jnz/jnc taken) from execute, flushes stale words and restarts fetch at the target.

---
 rtl/cpu_pkg.sv | 36 +++
 rtl/ifetch_fifo.sv | 61 ++++++
 rtl/ifetch_prefetch.sv | 117 +++++++++++
 tb/tb_ifetch_prefetch.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Desc     : Shared widths, opcode map and fetch FSM encoding for the
//            8-bit accumulator CPU.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int c_IW = 14;
    localparam int c_AW = 10;

    localparam logic [3:0] c_OP_NOP   = 4'b0000;
    localparam logic [3:0] c_OP_MVB   = 4'b0001;
    localparam logic [3:0] c_OP_LOAD  = 4'b0010;
    localparam logic [3:0] c_OP_STORE = 4'b0011;
    localparam logic [3:0] c_OP_XCHG  = 4'b0100;
    localparam logic [3:0] c_OP_JMP   = 4'b0101;
    localparam logic [3:0] c_OP_JZ    = 4'b0110;
    localparam logic [3:0] c_OP_JC    = 4'b0111;
    localparam logic [3:0] c_OP_JNZ   = 4'b1000;
    localparam logic [3:0] c_OP_JNC   = 4'b1001;
    localparam logic [3:0] c_OP_MVA   = 4'b1010;
    localparam logic [3:0] c_OP_AND   = 4'b1011;
    localparam logic [3:0] c_OP_OR    = 4'b1100;
    localparam logic [3:0] c_OP_NOT   = 4'b1101;
    localparam logic [3:0] c_OP_ADD   = 4'b1110;
    localparam logic [3:0] c_OP_SUB   = 4'b1111;

    localparam int                c_FS_W     = 2;
    localparam logic [c_FS_W-1:0] c_FS_BOOT  = 2'd0;
    localparam logic [c_FS_W-1:0] c_FS_RUN   = 2'd1;
    localparam logic [c_FS_W-1:0] c_FS_FLUSH = 2'd2;

endpackage
`default_nettype wire

// File: rtl/ifetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_fifo
// Desc     : DEPTH-entry synchronous FIFO holding {pc, word} pairs.
// Revision : 1.0 - initial release
// ============================================================================
module ifetch_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 24
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   clear,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int c_PW = $clog2(DEPTH);

    logic [W-1:0]    r_mem [DEPTH];
    logic [c_PW-1:0] r_wptr;
    logic [c_PW-1:0] r_rptr;
    logic [c_PW:0]   r_count;
    logic            w_do_push;
    logic            w_do_pop;

    // A push into a full FIFO is accepted only when the head leaves in the same cycle
    assign w_do_push = push && (!full || pop);
    assign w_do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + c_PW'(1);
            if (w_do_pop)  r_rptr <= r_rptr + c_PW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (c_PW+1)'(1);
                2'b01:   r_count <= r_count - (c_PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !clear) r_mem[r_wptr] <= din;
    end

    assign dout  = r_mem[r_rptr];
    assign count = r_count;
    assign full  = (r_count == (c_PW+1)'(DEPTH));
    assign empty = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/ifetch_prefetch.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_prefetch
// Desc     : Instruction fetch stage: PC, ROM read issue, prefetch FIFO and
//            redirect/flush handling feeding the execute stage.
// Revision : 1.0 - initial release
// ============================================================================
module ifetch_prefetch
    import cpu_pkg::*;
#(
    parameter int IW    = c_IW,
    parameter int AW    = c_AW,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    output logic          imem_en,
    output logic [AW-1:0] imem_addr,
    input  logic [IW-1:0] imem_data,
    output logic          ir_valid,
    output logic [IW-1:0] ir_data,
    output logic [AW-1:0] ir_pc,
    input  logic          ir_ready,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_addr
);
    localparam int c_CW = $clog2(DEPTH) + 1;

    logic [c_FS_W-1:0] r_state;
    logic [c_FS_W-1:0] w_state_nxt;
    logic [AW-1:0]     r_pc;
    logic [AW-1:0]     r_infl_pc;
    logic              r_epoch;
    logic              r_inflight;
    logic              r_infl_epoch;
    logic              w_issue;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [c_CW-1:0]   w_count;
    logic [c_CW:0]     w_load;
    logic [AW+IW-1:0]  w_head;

    assign w_pop  = ir_valid && ir_ready;
    assign w_push = r_inflight && (r_infl_epoch == r_epoch);

    // A word leaving this cycle frees its slot, which keeps a 1/cycle stream going
    assign w_load = {1'b0, w_count} + {{c_CW{1'b0}}, r_inflight} - {{c_CW{1'b0}}, w_pop};

    always_ff @(posedge clk) begin
        if (!rst) r_state <= c_FS_BOOT;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        case (r_state)
            c_FS_BOOT:  w_state_nxt = c_FS_RUN;
            c_FS_RUN:   w_issue     = (w_load < (c_CW+1)'(DEPTH));
            c_FS_FLUSH: w_state_nxt = c_FS_RUN;
            default:    w_state_nxt = c_FS_BOOT;
        endcase
        if (redirect) begin
            w_state_nxt = c_FS_FLUSH;
            w_issue     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pc         <= '0;
            r_epoch      <= 1'b0;
            r_inflight   <= 1'b0;
            r_infl_epoch <= 1'b0;
            r_infl_pc    <= '0;
        end else begin
            r_inflight   <= w_issue;
            r_infl_epoch <= r_epoch;
            if (w_issue) r_infl_pc <= r_pc;
            if (redirect) begin
                r_pc    <= redirect_addr;
                r_epoch <= ~r_epoch;
            end else if (w_issue) begin
                r_pc <= r_pc + AW'(1);
            end
        end
    end

    ifetch_fifo #(
        .DEPTH (DEPTH),
        .W     (AW + IW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .clear (redirect),
        .din   ({r_infl_pc, imem_data}),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    assign imem_en   = w_issue;
    assign imem_addr = r_pc;
    assign ir_valid  = !w_empty;
    assign ir_pc     = w_empty ? '0 : w_head[AW+IW-1:IW];
    assign ir_data   = w_empty ? '0 : w_head[IW-1:0];

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        (w_push && !redirect) |-> (!w_full || w_pop));

endmodule
`default_nettype wire

// File: tb/tb_ifetch_prefetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_ifetch_prefetch
// Desc     : Directed and randomised self-checking bench for ifetch_prefetch.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ifetch_prefetch;

    localparam int c_IW = 14;
    localparam int c_AW = 10;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            imem_en;
    logic [c_AW-1:0] imem_addr;
    logic [c_IW-1:0] imem_data = '0;
    logic            ir_valid;
    logic [c_IW-1:0] ir_data;
    logic [c_AW-1:0] ir_pc;
    logic            ir_ready = 1'b0;
    logic            redirect = 1'b0;
    logic [c_AW-1:0] redirect_addr = '0;

    logic [c_IW-1:0] rom [0:1023];
    int              n_cmp  = 0;
    int              n_fail = 0;

    ifetch_prefetch #(.IW(c_IW), .AW(c_AW), .DEPTH(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_en       (imem_en),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .ir_valid      (ir_valid),
        .ir_data       (ir_data),
        .ir_pc         (ir_pc),
        .ir_ready      (ir_ready),
        .redirect      (redirect),
        .redirect_addr (redirect_addr)
    );

    always #5 clk = ~clk;

    // Synchronous ROM with one-cycle read latency
    always @(posedge clk) if (imem_en) imem_data <= rom[imem_addr];

    // Holds reset across two edges; the next posedge is the first released one
    task automatic do_reset(input logic rdy);
        @(negedge clk);
        rst = 1'b0; ir_ready = 1'b0; redirect = 1'b0; redirect_addr = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1; ir_ready = rdy;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0; ir_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({imem_en, imem_addr} !== 11'd0) begin
            n_fail++; $display("FAIL reset_imem: got en=%b addr=%h want 0/000", imem_en, imem_addr);
        end
        n_cmp++;
        if ({ir_valid, ir_pc, ir_data} !== 25'd0) begin
            n_fail++; $display("FAIL reset_ir: got v=%b pc=%h d=%h want 0", ir_valid, ir_pc, ir_data);
        end
    endtask

    task automatic test_stream();
        do_reset(1'b1);
        @(negedge clk);
        n_cmp++;
        if ({ir_valid, imem_en, imem_addr} !== {1'b0, 1'b1, 10'h000}) begin
            n_fail++; $display("FAIL stream_first_issue: got v=%b en=%b addr=%h want 0/1/000", ir_valid, imem_en, imem_addr);
        end
        @(negedge clk);
        n_cmp++;
        if (ir_valid !== 1'b0) begin
            n_fail++; $display("FAIL stream_early_valid: got %b want 0", ir_valid);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({ir_valid, ir_pc, ir_data} !== {1'b1, 10'(k), rom[k]}) begin
                n_fail++; $display("FAIL stream_word%0d: got v=%b pc=%h d=%h want 1/%h/%h", k, ir_valid, ir_pc, ir_data, 10'(k), rom[k]);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset(1'b0);
        repeat (2) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({ir_valid, ir_pc, ir_data, imem_en} !== {1'b1, 10'h000, rom[0], 1'b0}) begin
                n_fail++; $display("FAIL bp_hold%0d: got v=%b pc=%h d=%h en=%b want 1/000/%h/0", k, ir_valid, ir_pc, ir_data, imem_en, rom[0]);
            end
        end
        ir_ready = 1'b1;
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({ir_valid, ir_pc, ir_data} !== {1'b1, 10'(k), rom[k]}) begin
                n_fail++; $display("FAIL bp_release%0d: got v=%b pc=%h d=%h want 1/%h/%h", k, ir_valid, ir_pc, ir_data, 10'(k), rom[k]);
            end
        end
    endtask

    task automatic test_redirect();
        logic [c_AW-1:0] exp_pc;
        do_reset(1'b1);
        repeat (8) @(negedge clk);
        n_cmp++;
        if ({ir_valid, ir_pc} !== {1'b1, 10'h005}) begin
            n_fail++; $display("FAIL redir_pre: got v=%b pc=%h want 1/005", ir_valid, ir_pc);
        end
        redirect = 1'b1; redirect_addr = 10'h3FE;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            redirect = 1'b0;
            n_cmp++;
            if (ir_valid !== 1'b0) begin
                n_fail++; $display("FAIL redir_gap%0d: got v=%b pc=%h want v=0", k, ir_valid, ir_pc);
            end
        end
        exp_pc = 10'h3FE;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({ir_valid, ir_pc, ir_data} !== {1'b1, exp_pc, rom[exp_pc]}) begin
                n_fail++; $display("FAIL redir_target%0d: got v=%b pc=%h d=%h want 1/%h/%h", k, ir_valid, ir_pc, ir_data, exp_pc, rom[exp_pc]);
            end
            exp_pc = exp_pc + 10'd1;
        end
    endtask

    task automatic test_back_to_back();
        logic [c_AW-1:0] exp_pc;
        do_reset(1'b1);
        repeat (4) @(negedge clk);
        redirect = 1'b1; redirect_addr = 10'h010;
        @(negedge clk);
        redirect_addr = 10'h020;
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (ir_valid !== 1'b0) begin
                n_fail++; $display("FAIL b2b_gap%0d: got v=%b pc=%h want v=0", k, ir_valid, ir_pc);
            end
            @(negedge clk);
            redirect = 1'b0;
        end
        exp_pc = 10'h020;
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if ({ir_valid, ir_pc, ir_data} !== {1'b1, exp_pc, rom[exp_pc]}) begin
                n_fail++; $display("FAIL b2b_target%0d: got v=%b pc=%h d=%h want 1/%h/%h", k, ir_valid, ir_pc, ir_data, exp_pc, rom[exp_pc]);
            end
            exp_pc = exp_pc + 10'd1;
            @(negedge clk);
        end
    endtask

    task automatic test_reset_midstream();
        do_reset(1'b1);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({ir_valid, ir_pc, ir_data, imem_en} !== 26'd0) begin
            n_fail++; $display("FAIL mid_reset_state: got v=%b pc=%h d=%h en=%b want all 0", ir_valid, ir_pc, ir_data, imem_en);
        end
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_cmp++;
            if (ir_valid !== 1'b0) begin
                n_fail++; $display("FAIL mid_stale%0d: got v=%b pc=%h want v=0", k, ir_valid, ir_pc);
            end
        end
        @(negedge clk);
        n_cmp++;
        if ({ir_valid, ir_pc, ir_data} !== {1'b1, 10'h000, rom[0]}) begin
            n_fail++; $display("FAIL mid_restart: got v=%b pc=%h d=%h want 1/000/%h", ir_valid, ir_pc, ir_data, rom[0]);
        end
    endtask

    task automatic test_random();
        logic [c_AW-1:0] exp_pc;
        int              n_xfer;
        exp_pc = '0;
        n_xfer = 0;
        do_reset(1'b0);
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            ir_ready      = ($urandom_range(9) < 7);
            redirect      = ($urandom_range(39) == 0);
            redirect_addr = 10'($urandom_range(1023));
            if (ir_valid && ir_ready) begin
                n_cmp++;
                if ({ir_pc, ir_data} !== {exp_pc, rom[exp_pc]}) begin
                    n_fail++; $display("FAIL rand_xfer cycle %0d: got pc=%h d=%h want %h/%h", c, ir_pc, ir_data, exp_pc, rom[exp_pc]);
                end
                exp_pc = exp_pc + 10'd1;
                n_xfer++;
            end
            if (redirect) exp_pc = redirect_addr;
        end
        @(negedge clk);
        redirect = 1'b0; ir_ready = 1'b0;
        n_cmp++;
        if (n_xfer < 2000) begin
            n_fail++; $display("FAIL rand_progress: got %0d transfers want >= 2000", n_xfer);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = 14'(i * 37 + 5);
        rom[0] = 14'h2805;
        rom[1] = 14'h0000;
        rom[2] = 14'h0404;
        rom[3] = 14'h0000;

        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_back_to_back();
        test_reset_midstream();
        test_random();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
